// File: rtl/br_flow_mux_wrr_stable_if.sv
// Push/pop handshake bundle for br_flow_mux_wrr_stable.
// master = the mux itself, slave = the surrounding flows and downstream sink.
interface br_flow_mux_wrr_stable_if #(
  parameter int unsigned NumFlows    = 4,
  parameter int unsigned Width       = 8,
  parameter int unsigned WeightWidth = 4,
  parameter int unsigned CountWidth  = 16
);
  localparam int unsigned IdW = $clog2(NumFlows);

  logic [NumFlows-1:0]                  push_valid;
  logic [NumFlows-1:0]                  push_ready;
  logic [NumFlows-1:0][Width-1:0]       push_data;
  logic [NumFlows-1:0]                  push_last;
  logic [NumFlows-1:0][WeightWidth-1:0] weight;
  logic                                 pop_valid;
  logic                                 pop_ready;
  logic [Width-1:0]                     pop_data;
  logic                                 pop_last;
  logic [IdW-1:0]                       pop_flow_id;
  logic [NumFlows-1:0][CountWidth-1:0]  grant_count;

  modport master (
    input  push_valid, push_data, push_last, weight, pop_ready,
    output push_ready, pop_valid, pop_data, pop_last, pop_flow_id, grant_count
  );

  modport slave (
    output push_valid, push_data, push_last, weight, pop_ready,
    input  push_ready, pop_valid, pop_data, pop_last, pop_flow_id, grant_count
  );
endinterface

// File: rtl/br_flow_mux_wrr_stable.sv
// N-to-1 weighted round-robin flow mux with packet locking and a registered pop stage.
// Define BR_FLOW_MUX_WRR_GRANT_COUNT_EN to build saturating per-flow grant counters.
module br_flow_mux_wrr_stable #(
  parameter int unsigned NumFlows       = 4,
  parameter int unsigned Width          = 8,
  parameter int unsigned WeightWidth    = 4,
  parameter int unsigned EnableLastLock = 1,
  parameter int unsigned CountWidth     = 16
) (
  input logic                     clk,
  input logic                     rst_n,
  br_flow_mux_wrr_stable_if.master bus
);
  localparam int unsigned IdW = $clog2(NumFlows);

  typedef enum logic {
    S_ARB,
    S_LOCKED
  } state_t;

  state_t                 r_state;
  logic [IdW-1:0]         r_lock_id;
  logic [IdW-1:0]         r_ptr;
  logic [WeightWidth-1:0] r_credit;

  logic [NumFlows-1:0]    w_gnt;
  logic [IdW-1:0]         w_gnt_id;
  logic [IdW-1:0]         w_idx;
  logic [IdW-1:0]         w_next_ptr;
  logic [WeightWidth-1:0] w_eff;
  logic                   w_found;
  logic                   w_can_accept;
  logic                   w_accept;
  logic                   w_unit;

  always_comb begin
    w_gnt    = '0;
    w_gnt_id = '0;
    w_idx    = '0;
    w_found  = 1'b0;
    if (r_state == S_LOCKED) begin
      w_gnt_id = r_lock_id;
      w_found  = bus.push_valid[r_lock_id];
    end else begin
      for (int unsigned k = 0; k < NumFlows; k++) begin
        w_idx = IdW'((32'(r_ptr) + k) % NumFlows);
        if (!w_found && bus.push_valid[w_idx]) begin
          w_found  = 1'b1;
          w_gnt_id = w_idx;
        end
      end
    end
    if (w_found) w_gnt[w_gnt_id] = 1'b1;
  end

  assign w_can_accept   = !bus.pop_valid || bus.pop_ready;
  assign bus.push_ready = w_can_accept ? w_gnt : '0;
  assign w_accept       = w_can_accept && w_found;
  assign w_unit         = w_accept && ((EnableLastLock == 0) || bus.push_last[w_gnt_id]);

  // A unit from a flow other than ptr restarts the quota from that flow's weight.
  always_comb begin
    w_eff = (w_gnt_id != r_ptr || r_credit == '0) ? bus.weight[w_gnt_id] : r_credit;
    if (w_eff == '0) w_eff = WeightWidth'(1);
    w_next_ptr = (w_gnt_id == IdW'(NumFlows - 1)) ? '0 : w_gnt_id + IdW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_ARB;
      r_lock_id       <= '0;
      r_ptr           <= '0;
      r_credit        <= '0;
      bus.pop_valid   <= 1'b0;
      bus.pop_data    <= '0;
      bus.pop_last    <= 1'b0;
      bus.pop_flow_id <= '0;
    end else begin
      if (w_unit) begin
        if (w_eff == WeightWidth'(1)) begin
          r_ptr    <= w_next_ptr;
          r_credit <= '0;
        end else begin
          r_ptr    <= w_gnt_id;
          r_credit <= w_eff - WeightWidth'(1);
        end
      end
      if (w_accept && EnableLastLock != 0) begin
        if (bus.push_last[w_gnt_id]) begin
          r_state <= S_ARB;
        end else begin
          r_state   <= S_LOCKED;
          r_lock_id <= w_gnt_id;
        end
      end
      if (w_can_accept) begin
        bus.pop_valid <= w_accept;
        if (w_accept) begin
          bus.pop_data    <= bus.push_data[w_gnt_id];
          bus.pop_last    <= bus.push_last[w_gnt_id];
          bus.pop_flow_id <= w_gnt_id;
        end
      end
    end
  end

`ifdef BR_FLOW_MUX_WRR_GRANT_COUNT_EN
  logic [NumFlows-1:0][CountWidth-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < NumFlows; i++) begin
        if (bus.push_valid[i] && bus.push_ready[i] && r_cnt[i] != '1)
          r_cnt[i] <= r_cnt[i] + CountWidth'(1);
      end
    end
  end

  assign bus.grant_count = r_cnt;
`else
  assign bus.grant_count = '0;
`endif
endmodule

// File: tb/tb_br_flow_mux_wrr_stable.sv
// Scoreboard bench for br_flow_mux_wrr_stable: directed per-flow beat queues in,
// hand-ordered expected pops checked by an independent monitor.
module tb_br_flow_mux_wrr_stable;
  localparam int NF = 4;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } beat_t;

  typedef struct {
    logic [1:0] id;
    logic [7:0] d;
    logic       l;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;
  beat_t src [NF][$];
  exp_t  exp_q[$];

  br_flow_mux_wrr_stable_if #(
    .NumFlows(4), .Width(8), .WeightWidth(4), .CountWidth(8)
  ) bus ();

  br_flow_mux_wrr_stable #(
    .NumFlows(4), .Width(8), .WeightWidth(4), .EnableLastLock(1), .CountWidth(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.pop_valid === 1'b1 && bus.pop_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", 32'(bus.pop_data), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pop_flow_id", 32'(bus.pop_flow_id), 32'(e.id));
        chk("pop_data", 32'(bus.pop_data), 32'(e.d));
        chk("pop_last", 32'(bus.pop_last), 32'(e.l));
      end
    end
  end

  task automatic drive();
    for (int f = 0; f < NF; f++) begin
      if (src[f].size() > 0) begin
        bus.push_valid[f] = 1'b1;
        bus.push_data[f]  = src[f][0].d;
        bus.push_last[f]  = src[f][0].l;
      end else begin
        bus.push_valid[f] = 1'b0;
        bus.push_data[f]  = '0;
        bus.push_last[f]  = 1'b0;
      end
    end
  endtask

  task automatic step();
    logic [NF-1:0] fire;
    @(negedge clk);
    fire = bus.push_valid & bus.push_ready;
    @(posedge clk);
    #1;
    for (int f = 0; f < NF; f++)
      if (fire[f] && src[f].size() > 0) void'(src[f].pop_front());
    drive();
  endtask

  task automatic add(input int f, input logic [7:0] d, input logic l);
    beat_t b;
    b.d = d;
    b.l = l;
    src[f].push_back(b);
  endtask

  task automatic expect_pop(input logic [1:0] id, input logic [7:0] d, input logic l);
    exp_t e;
    e.id = id;
    e.d  = d;
    e.l  = l;
    exp_q.push_back(e);
  endtask

  task automatic drain(input int limit, output int n);
    n = 0;
    while (exp_q.size() > 0 && n < limit) begin
      step();
      n++;
    end
    if (exp_q.size() > 0) begin
      chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int f = 0; f < NF; f++) src[f].delete();
    exp_q.delete();
    drive();
    bus.pop_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic set_weights(input logic [3:0] w0, input logic [3:0] w1,
                             input logic [3:0] w2, input logic [3:0] w3);
    bus.weight[0] = w0;
    bus.weight[1] = w1;
    bus.weight[2] = w2;
    bus.weight[3] = w3;
  endtask

  initial begin
    int n;
    bus.pop_ready = 1'b1;
    set_weights(4'd1, 4'd1, 4'd1, 4'd1);
    drive();

    // Reset state
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_pop_valid", 32'(bus.pop_valid), 32'd0);
    chk("rst_push_ready", 32'(bus.push_ready), 32'd0);
    chk("rst_grant_count", 32'(bus.grant_count), 32'd0);
    #1 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_push_ready", 32'(bus.push_ready), 32'd0);
      chk("idle_pop_valid", 32'(bus.pop_valid), 32'd0);
    end

    // Weights {2,1,1,1}, single-beat packets: 0,0,1,2,3,0,0,1,2,3
    do_reset();
    set_weights(4'd2, 4'd1, 4'd1, 4'd1);
    for (int k = 0; k < 4; k++) add(0, 8'h00 + 8'(k), 1'b1);
    for (int k = 0; k < 2; k++) begin
      add(1, 8'h10 + 8'(k), 1'b1);
      add(2, 8'h20 + 8'(k), 1'b1);
      add(3, 8'h30 + 8'(k), 1'b1);
    end
    expect_pop(2'd0, 8'h00, 1'b1); expect_pop(2'd0, 8'h01, 1'b1);
    expect_pop(2'd1, 8'h10, 1'b1); expect_pop(2'd2, 8'h20, 1'b1);
    expect_pop(2'd3, 8'h30, 1'b1); expect_pop(2'd0, 8'h02, 1'b1);
    expect_pop(2'd0, 8'h03, 1'b1); expect_pop(2'd1, 8'h11, 1'b1);
    expect_pop(2'd2, 8'h21, 1'b1); expect_pop(2'd3, 8'h31, 1'b1);
    drive();
    drain(50, n);
    chk("wrr_throughput_cycles", 32'(n), 32'd11);

    // Packet lock: flow 1 three-beat packet with flow 0 waiting at ptr=1
    do_reset();
    set_weights(4'd1, 4'd1, 4'd1, 4'd1);
    add(0, 8'h40, 1'b1); add(0, 8'h41, 1'b1);
    add(1, 8'h50, 1'b0); add(1, 8'h51, 1'b0); add(1, 8'h52, 1'b1);
    add(2, 8'h60, 1'b1);
    expect_pop(2'd0, 8'h40, 1'b1);
    expect_pop(2'd1, 8'h50, 1'b0); expect_pop(2'd1, 8'h51, 1'b0);
    expect_pop(2'd1, 8'h52, 1'b1);
    expect_pop(2'd2, 8'h60, 1'b1); expect_pop(2'd0, 8'h41, 1'b1);
    drive();
    drain(50, n);

    // Back-pressure: 0xA5 from flow 2 must hold for 5 stalled cycles
    do_reset();
    bus.pop_ready = 1'b0;
    add(2, 8'hA5, 1'b1);
    add(3, 8'h3C, 1'b1);
    expect_pop(2'd2, 8'hA5, 1'b1);
    expect_pop(2'd3, 8'h3C, 1'b1);
    drive();
    step();
    repeat (5) begin
      @(negedge clk);
      chk("stall_pop_valid", 32'(bus.pop_valid), 32'd1);
      chk("stall_pop_data", 32'(bus.pop_data), 32'hA5);
      chk("stall_pop_flow_id", 32'(bus.pop_flow_id), 32'd2);
      chk("stall_push_ready", 32'(bus.push_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    bus.pop_ready = 1'b1;
    drain(50, n);

    // Weight 0 behaves as 1: flows 2 and 3 strictly alternate
    do_reset();
    set_weights(4'd1, 4'd1, 4'd0, 4'd1);
    for (int k = 0; k < 3; k++) begin
      add(2, 8'h70 + 8'(k), 1'b1);
      add(3, 8'h80 + 8'(k), 1'b1);
    end
    expect_pop(2'd2, 8'h70, 1'b1); expect_pop(2'd3, 8'h80, 1'b1);
    expect_pop(2'd2, 8'h71, 1'b1); expect_pop(2'd3, 8'h81, 1'b1);
    expect_pop(2'd2, 8'h72, 1'b1); expect_pop(2'd3, 8'h82, 1'b1);
    drive();
    drain(50, n);

    // Grant counter: 300 beats from flow 0 saturate an 8-bit counter
    do_reset();
    set_weights(4'd1, 4'd1, 4'd1, 4'd1);
    for (int k = 0; k < 300; k++) begin
      add(0, 8'(k), 1'b1);
      expect_pop(2'd0, 8'(k), 1'b1);
    end
    drive();
    drain(400, n);
`ifdef BR_FLOW_MUX_WRR_GRANT_COUNT_EN
    chk("grant_count0", 32'(bus.grant_count[0]), 32'd255);
`else
    chk("grant_count0", 32'(bus.grant_count[0]), 32'd0);
`endif
    chk("grant_count1", 32'(bus.grant_count[1]), 32'd0);
    chk("grant_count2", 32'(bus.grant_count[2]), 32'd0);
    chk("grant_count3", 32'(bus.grant_count[3]), 32'd0);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
